// File: rtl/wall_texv_stepper.sv
`timescale 1ns/1ps
// wall_texv_stepper
// Per-line texture-row generator feeding the wall texture memory.
// During blanking a load pulse latches the wall's span size, side and
// texture column. The block then computes a Q6.F row step
// (2^(6+F) / size) with a restoring divider and a clip offset
// (clip * step) with a shift-add multiplier. In the visible span it emits
// one texture row per pixel and a wall-enable flag.
//
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   load     : one-cycle pulse, samples size / side_in / col_in
//   size     : wall span in pixels (0..1023)
//   side_in  : wall side (X/Y face)
//   col_in   : texture column (u)
//   pix_pos  : current pixel index along the span axis
//   ready    : step and offset valid, span output enabled
//   wall_en  : current pixel lies on the wall
//   tex_side : texture memory side address
//   tex_col  : texture memory column address
//   tex_row  : texture memory row address
module wall_texv_stepper #(
  parameter int H = 480,
  parameter int F = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] size,
  input  logic       side_in,
  input  logic [5:0] col_in,
  input  logic [9:0] pix_pos,
  output logic       ready,
  output logic       wall_en,
  output logic       tex_side,
  output logic [5:0] tex_col,
  output logic [5:0] tex_row
);

  localparam int AW = 6 + F;          // accumulator / stored step width
  localparam int QW = 7 + F;          // quotient bits produced by the divider
  localparam int MW = 10;             // multiplier (clip) bits
  localparam int CW = $clog2(QW);
  localparam logic [9:0] HW = 10'(H);

  typedef enum logic [1:0] {IDLE, DIV, MUL, READY} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [9:0]      r_size;
  logic            r_side;
  logic [5:0]      r_col;
  logic [9:0]      r_rem;
  // The full quotient is QW bits, but only its value mod 2^AW ever reaches
  // the accumulator or the clip product, so the top bit is dropped.
  logic [AW-1:0]   r_step;
  logic [AW-1:0]   r_mcand;
  logic [MW-1:0]   r_mplier;
  logic [AW-1:0]   r_init;
  logic [AW-1:0]   r_acc;
  logic            r_ready;
  logic            r_wall_en;
  logic            r_tex_side;
  logic [5:0]      r_tex_col;
  logic [5:0]      r_tex_row;

  logic            w_div_act;
  logic            w_mul_act;
  logic            w_ready_st;
  logic            w_div_last;
  logic            w_mul_last;
  logic            w_div_bit;
  logic [10:0]     w_rem_sh;
  logic [10:0]     w_rem_diff;
  logic            w_ge;
  logic [AW-1:0]   w_step_nxt;
  logic [9:0]      w_clip;
  logic [9:0]      w_start;
  logic [9:0]      w_end;
  logic            w_in_span;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of statement order.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a load from any state restarts the computation.
  always_comb begin
    // NOTE: default first so no path through this block leaves the signal
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = (size == 10'd0) ? READY : DIV;
    end else begin
      unique case (r_state)
        IDLE:    w_state_nxt = IDLE;
        DIV:     if (w_div_last) w_state_nxt = MUL;
        MUL:     if (w_mul_last) w_state_nxt = READY;
        READY:   w_state_nxt = READY;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State decode
  always_comb begin
    w_div_act  = (r_state == DIV);
    w_mul_act  = (r_state == MUL);
    w_ready_st = (r_state == READY);
    w_div_last = w_div_act && (r_cnt == CW'(QW - 1));
    w_mul_last = w_mul_act && (r_cnt == CW'(MW - 1));
  end

  // Restoring divide of 2^(6+F) by size: the dividend's only set bit is its
  // MSB, so it enters on the first iteration and zeros follow. The remainder
  // stays below size, so the 11-bit difference sign is a valid compare.
  assign w_div_bit  = (r_cnt == '0);
  assign w_rem_sh   = {r_rem, w_div_bit};
  assign w_rem_diff = w_rem_sh - {1'b0, r_size};
  assign w_ge       = ~w_rem_diff[10];
  assign w_step_nxt = {r_step[AW-2:0], w_ge};

  // Span geometry from the latched size
  assign w_clip  = (r_size > HW) ? ((r_size - HW) >> 1) : 10'd0;
  assign w_start = (r_size <= HW) ? ((HW - r_size) >> 1) : 10'd0;
  assign w_end   = (r_size <= HW) ? (w_start + r_size) : HW;
  // A load in the same cycle kills the span so wall_en drops with ready.
  assign w_in_span = r_ready && !load && (pix_pos >= w_start) && (pix_pos < w_end);

  // Divide / multiply datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_size   <= '0;
      r_side   <= 1'b0;
      r_col    <= '0;
      r_rem    <= '0;
      r_step   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_init   <= '0;
    end else if (load) begin
      r_cnt    <= '0;
      r_size   <= size;
      r_side   <= side_in;
      r_col    <= col_in;
      r_rem    <= '0;
      r_step   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_init   <= '0;
    end else if (w_div_act) begin
      r_rem  <= w_ge ? w_rem_diff[9:0] : w_rem_sh[9:0];
      r_step <= w_step_nxt;
      if (w_div_last) begin
        r_cnt    <= '0;
        r_mcand  <= w_step_nxt;
        r_mplier <= w_clip;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (w_mul_act) begin
      // Product wraps mod 2^AW, matching the 64-row texture wrap.
      if (r_mplier[0]) r_init <= r_init + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Span accumulator and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_acc      <= '0;
      r_wall_en  <= 1'b0;
      r_tex_side <= 1'b0;
      r_tex_col  <= '0;
      r_tex_row  <= '0;
    end else begin
      r_ready    <= w_ready_st && !load;
      // Reloading init whenever off-span makes every line restart identically.
      r_acc      <= w_in_span ? (r_acc + r_step) : r_init;
      r_wall_en  <= w_in_span;
      r_tex_row  <= r_acc[F+5:F];
      r_tex_side <= r_side;
      r_tex_col  <= r_col;
    end
  end

  assign ready    = r_ready;
  assign wall_en  = r_wall_en;
  assign tex_side = r_tex_side;
  assign tex_col  = r_tex_col;
  assign tex_row  = r_tex_row;

endmodule

// File: tb/tb_wall_texv_stepper.sv
`timescale 1ns/1ps
// Self-checking bench for wall_texv_stepper. Expected rows come from a
// closed-form model: row(p) = ((init + (p - start) * step) >> F) mod 64.
module tb_wall_texv_stepper;

  localparam int H  = 480;
  localparam int F  = 12;
  localparam int AW = 6 + F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [9:0] size = '0;
  logic       side_in = 1'b0;
  logic [5:0] col_in = '0;
  logic [9:0] pix_pos = 10'd1023;
  logic       ready;
  logic       wall_en;
  logic       tex_side;
  logic [5:0] tex_col;
  logic [5:0] tex_row;

  int n_vec = 0;
  int n_err = 0;

  wall_texv_stepper #(.H(H), .F(F)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .size     (size),
    .side_in  (side_in),
    .col_in   (col_in),
    .pix_pos  (pix_pos),
    .ready    (ready),
    .wall_en  (wall_en),
    .tex_side (tex_side),
    .tex_col  (tex_col),
    .tex_row  (tex_row)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_start(input int sz);
    return (sz <= H) ? (H - sz) / 2 : 0;
  endfunction

  function automatic int m_end(input int sz);
    return (sz <= H) ? m_start(sz) + sz : H;
  endfunction

  function automatic longint m_step(input int sz);
    return (sz == 0) ? 64'd0 : (longint'(1) << (6 + F)) / sz;
  endfunction

  function automatic longint m_init(input int sz);
    longint clip;
    clip = (sz > H) ? (sz - H) / 2 : 0;
    return (clip * m_step(sz)) % (longint'(1) << AW);
  endfunction

  function automatic int m_row(input int sz, input int p);
    longint v;
    v = m_init(sz) + longint'(p - m_start(sz)) * m_step(sz);
    return int'((v >> F) % 64);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse_load(input int sz, input logic sd, input logic [5:0] cl);
    @(negedge clk);
    size = 10'(sz); side_in = sd; col_in = cl; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("ready_fall", 32'(ready), 32'd0);
    check("wall_en_fall", 32'(wall_en), 32'd0);
  endtask

  task automatic wait_ready(input int sz);
    int lat;
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
    check("ready_latency", 32'(lat), 32'((sz == 0) ? 1 : 30));
  endtask

  task automatic do_load(input int sz, input logic sd, input logic [5:0] cl);
    pulse_load(sz, sd, cl);
    wait_ready(sz);
  endtask

  task automatic sweep(input int sz, input logic sd, input logic [5:0] cl);
    int st, en;
    logic e;
    st = m_start(sz);
    en = m_end(sz);
    for (int p = 0; p < 1024; p++) begin
      @(negedge clk);
      pix_pos = 10'(p);
      @(posedge clk); #1;
      e = (p >= st) && (p < en);
      check("wall_en", 32'(wall_en), 32'(e));
      if (e) check("tex_row", 32'(tex_row), 32'(m_row(sz, p)));
    end
    check("tex_side", 32'(tex_side), 32'(sd));
    check("tex_col", 32'(tex_col), 32'(cl));
    @(negedge clk);
    pix_pos = 10'd1023;
  endtask

  task automatic check_quiet(input int cycles, input logic [9:0] p);
    @(negedge clk);
    pix_pos = p;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 32'(ready), 32'd0);
      check("idle_wall_en", 32'(wall_en), 32'd0);
    end
    @(negedge clk);
    pix_pos = 10'd1023;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_wall_en"}, 32'(wall_en), 32'd0);
    check({tag, "_tex_side"}, 32'(tex_side), 32'd0);
    check({tag, "_tex_col"}, 32'(tex_col), 32'd0);
    check({tag, "_tex_row"}, 32'(tex_row), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sz;
    logic sd;
    logic [5:0] cl;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Centered wall, one row per pixel
    do_load(64, 1'b1, 6'd37);
    sweep(64, 1'b1, 6'd37);

    // Two pixels per row, repeated line without reload
    do_load(128, 1'b0, 6'd5);
    sweep(128, 1'b0, 6'd5);
    sweep(128, 1'b0, 6'd5);

    // A load inside an active span drops wall_en at the same edge
    @(negedge clk);
    pix_pos = 10'd200;
    @(posedge clk); #1;
    check("span_before_load", 32'(wall_en), 32'd1);
    pulse_load(960, 1'b1, 6'd63);
    pix_pos = 10'd1023;
    wait_ready(960);
    sweep(960, 1'b1, 6'd63);

    // Zero size: ready next cycle, no span
    do_load(0, 1'b1, 6'd2);
    sweep(0, 1'b1, 6'd2);

    // Smallest and largest sizes
    do_load(1, 1'b0, 6'd17);
    sweep(1, 1'b0, 6'd17);
    do_load(1023, 1'b1, 6'd48);
    sweep(1023, 1'b1, 6'd48);

    // Random walls
    for (int i = 0; i < 6; i++) begin
      sz = int'($urandom_range(1, 1023));
      sd = 1'($urandom_range(0, 1));
      cl = 6'($urandom_range(0, 63));
      do_load(sz, sd, cl);
      sweep(sz, sd, cl);
    end

    // Load aborted mid-divide; only the second load counts
    pulse_load(64, 1'b0, 6'd9);
    repeat (9) @(posedge clk);
    #1;
    do_load(32, 1'b1, 6'd20);
    sweep(32, 1'b1, 6'd20);

    // Reset during the multiply phase
    pulse_load(200, 1'b1, 6'd44);
    repeat (24) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_mul");
    @(negedge clk);
    reset = 1'b0;
    check_quiet(40, 10'd300);

    // Reset during an active span
    do_load(100, 1'b1, 6'd12);
    for (int p = 190; p < 210; p++) begin
      @(negedge clk);
      pix_pos = 10'(p);
      @(posedge clk); #1;
      check("pre_rst_wall_en", 32'(wall_en), 32'd1);
      check("pre_rst_tex_row", 32'(tex_row), 32'(m_row(100, p)));
    end
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_span");
    @(negedge clk);
    reset = 1'b0;
    check_quiet(40, 10'd250);

    // Recovery after reset
    do_load(100, 1'b1, 6'd12);
    sweep(100, 1'b1, 6'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
